// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and default geometry for the boot loader
package boot_loader_pkg;
  typedef enum logic [2:0] {HDR, LOAD, WRITE, DONE, ERR} boot_state_t;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
  localparam int DEF_MAX_WORDS = 1024;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream handshake plus core-side and memory-side ports
interface boot_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic [31:0] core_adr;
  logic core_we;
  logic [31:0] core_wd;
  logic [31:0] mem_adr;
  logic mem_we;
  logic [31:0] mem_wd;
  modport master (
    output rx_data, rx_valid, core_adr, core_we, core_wd,
    input rx_ready, mem_adr, mem_we, mem_wd
  );
  modport slave (
    input rx_data, rx_valid, core_adr, core_we, core_wd,
    output rx_ready, mem_adr, mem_we, mem_wd
  );
endinterface

// File: rtl/boot_loader_byte_assembler.sv
// boot_loader_byte_assembler: packs four accepted bytes little-endian into a word
module boot_loader_byte_assembler (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] byte_i,
  input  logic valid_i,
  output logic [31:0] word_o,
  output logic word_valid_o
);
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  // new bytes enter at the top so the first byte ends up in bits [7:0]
  always_comb begin
    sh_d = valid_i ? {byte_i, sh_q[31:8]} : sh_q;
    cnt_d = valid_i ? cnt_q + 2'd1 : cnt_q;
  end
  assign word_o = sh_d;
  assign word_valid_o = valid_i && cnt_q == 2'd3;
  // byte counter and shift register; the counter wraps on the word boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed byte image into memory, then hands the port to the core
module boot_loader import boot_loader_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic clk,
  input  logic rst,
  boot_loader_if.slave bus,
  output logic core_rst,
  output logic boot_done,
  output logic boot_err
);
  boot_state_t state_q;
  logic [31:0] idx_q, n_q, wd_q, word;
  logic accept, word_valid;
  assign bus.rx_ready = (state_q == HDR || state_q == LOAD) && !rst;
  assign accept = bus.rx_valid && bus.rx_ready;
  boot_loader_byte_assembler u_asm (
    .clk(clk),
    .rst(rst),
    .byte_i(bus.rx_data),
    .valid_i(accept),
    .word_o(word),
    .word_valid_o(word_valid)
  );
  // load sequencer: header, then alternating word collection and memory write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      idx_q <= '0;
      n_q <= '0;
      wd_q <= '0;
    end else begin
      case (state_q)
        HDR: if (word_valid) begin
          n_q <= word;
          state_q <= word == '0 ? DONE : word > 32'(MAX_WORDS) ? ERR : LOAD;
        end
        LOAD: if (word_valid) begin
          wd_q <= word;
          state_q <= WRITE;
        end
        WRITE: if (idx_q == n_q - 32'd1) state_q <= DONE;
        else begin
          idx_q <= idx_q + 32'd1;
          state_q <= LOAD;
        end
        default: ;
      endcase
    end
  end
  assign bus.mem_we = state_q == WRITE || (state_q == DONE && bus.core_we);
  assign bus.mem_adr = state_q == DONE ? bus.core_adr : state_q == WRITE ? BASE_ADDR + (idx_q << 2) : BASE_ADDR;
  assign bus.mem_wd = state_q == DONE ? bus.core_wd : state_q == WRITE ? wd_q : '0;
  assign core_rst = state_q != DONE;
  assign boot_done = state_q == DONE;
  assign boot_err = state_q == ERR;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized image streams checked against a byte-level image model
module tb_boot_loader;
  import boot_loader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, boot_done, boot_err;
  boot_loader_if bus();
  boot_loader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .core_rst(core_rst),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [7:0] img_q[$];
  logic [7:0] tx_q[$];
  logic [31:0] wr_adr[$];
  logic [31:0] wr_wd[$];
  int wr_edge[$];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.core_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic make_image(input logic [31:0] n, input int words);
    img_q.delete();
    for (int i = 0; i < 4; i++) img_q.push_back(n[8*i +: 8]);
    for (int i = 0; i < 4 * words; i++) img_q.push_back(8'($urandom_range(255)));
    tx_q = img_q;
  endtask

  task automatic run_stream(input int gap_pct, input bit toggle, input int max_cyc,
                            output int done_edge, output int err_edge);
    int e;
    bit ph, v, acc;
    e = 0;
    ph = 1'b0;
    done_edge = -1;
    err_edge = -1;
    wr_adr.delete();
    wr_wd.delete();
    wr_edge.delete();
    while (e < max_cyc) begin
      if (bus.mem_we) begin
        wr_adr.push_back(bus.mem_adr);
        wr_wd.push_back(bus.mem_wd);
        wr_edge.push_back(e + 1);
      end
      if (boot_done) begin
        done_edge = e;
        break;
      end
      if (boot_err) begin
        err_edge = e;
        break;
      end
      v = tx_q.size() > 0 && (toggle ? ph : $urandom_range(99) >= gap_pct);
      ph = ~ph;
      bus.rx_valid = v;
      bus.rx_data = v ? tx_q[0] : 8'h00;
      acc = v && bus.rx_ready;
      @(posedge clk);
      e++;
      if (acc) void'(tx_q.pop_front());
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_writes(input string name);
    logic [31:0] n, w, a;
    int cnt;
    n = {img_q[3], img_q[2], img_q[1], img_q[0]};
    cnt = (n == 32'd0 || n > 32'(DEF_MAX_WORDS)) ? 0 : int'(n);
    checks++;
    if (wr_adr.size() !== cnt) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_adr.size(), cnt);
    end
    for (int i = 0; i < cnt && i < wr_adr.size(); i++) begin
      w = {img_q[4*i+7], img_q[4*i+6], img_q[4*i+5], img_q[4*i+4]};
      a = DEF_BASE_ADDR + 32'(4 * i);
      checks++;
      if (wr_adr[i] !== a || wr_wd[i] !== w) begin
        errors++;
        $display("FAIL %s word%0d: got %h@%h expected %h@%h", name, i, wr_wd[i], wr_adr[i], w, a);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.rx_ready, bus.mem_we, core_rst, boot_done, boot_err} !== 5'b00100 ||
        bus.mem_adr !== DEF_BASE_ADDR || bus.mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy%b we%b crst%b done%b err%b adr%h wd%h expected 0 0 1 0 0 %h 0",
               bus.rx_ready, bus.mem_we, core_rst, boot_done, boot_err, bus.mem_adr, bus.mem_wd, DEF_BASE_ADDR);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got rdy%b crst%b expected rdy1 crst1", bus.rx_ready, core_rst);
    end
  endtask

  task automatic test_plan_n2();
    int d, e;
    do_reset();
    img_q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h93, 8'h00, 8'h10, 8'h00, 8'h6F};
    tx_q = img_q;
    run_stream(0, 1'b0, 200, d, e);
    checks++;
    if (wr_adr.size() != 2) begin
      errors++;
      $display("FAIL n2_count: got %0d expected 2", wr_adr.size());
    end else begin
      checks++;
      if (wr_adr[0] !== 32'h0 || wr_wd[0] !== 32'h93500013 || wr_edge[0] != 9) begin
        errors++;
        $display("FAIL n2_write0: got %h@%h edge %0d expected 93500013@0 edge 9", wr_wd[0], wr_adr[0], wr_edge[0]);
      end
      checks++;
      if (wr_adr[1] !== 32'h4 || wr_wd[1] !== 32'h6F001000 || wr_edge[1] != 14) begin
        errors++;
        $display("FAIL n2_write1: got %h@%h edge %0d expected 6f001000@4 edge 14", wr_wd[1], wr_adr[1], wr_edge[1]);
      end
    end
    checks++;
    if (d != 14 || core_rst !== 1'b0 || boot_done !== 1'b1) begin
      errors++;
      $display("FAIL n2_done: got edge %0d crst%b done%b expected edge 14 crst0 done1", d, core_rst, boot_done);
    end
  endtask

  task automatic test_zero();
    int d, e;
    do_reset();
    make_image(32'd0, 0);
    run_stream(0, 1'b0, 200, d, e);
    checks++;
    if (d != 4 || wr_adr.size() != 0) begin
      errors++;
      $display("FAIL zero_hdr: got done edge %0d writes %0d expected 4 and 0", d, wr_adr.size());
    end
  endtask

  task automatic test_err(input logic [31:0] n);
    int d, e;
    bit bad;
    do_reset();
    make_image(n, 2);
    run_stream(0, 1'b0, 200, d, e);
    checks++;
    if (e != 4 || d != -1) begin
      errors++;
      $display("FAIL err_hdr %h: got err edge %0d done edge %0d expected 4 and -1", n, e, d);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'($urandom_range(255));
      @(negedge clk);
      if (bus.rx_ready !== 1'b0 || core_rst !== 1'b1 || boot_err !== 1'b1 || bus.mem_we !== 1'b0) bad = 1'b1;
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL err_hold: got rdy%b crst%b err%b we%b expected 0 1 1 0", bus.rx_ready, core_rst, boot_err, bus.mem_we);
    end
  endtask

  task automatic test_toggle();
    int d, e;
    do_reset();
    make_image(32'd1, 1);
    run_stream(0, 1'b1, 200, d, e);
    checks++;
    if (d < 0) begin
      errors++;
      $display("FAIL toggle_done: got timeout expected done");
    end
    check_writes("toggle");
  endtask

  task automatic test_random();
    int d, e, n, gap;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      gap = (r % 2) ? 35 : 0;
      do_reset();
      make_image(32'(n), n);
      run_stream(gap, 1'b0, 2000, d, e);
      checks++;
      if (d < 0 || (gap == 0 && d != 4 + 5 * n)) begin
        errors++;
        $display("FAIL random%0d_done: got edge %0d expected %0d (gap %0d)", r, d, 4 + 5 * n, gap);
      end
      check_writes("random");
    end
  endtask

  task automatic test_max();
    int d, e;
    do_reset();
    make_image(32'(DEF_MAX_WORDS), DEF_MAX_WORDS);
    run_stream(0, 1'b0, 6000, d, e);
    checks++;
    if (d != 4 + 5 * DEF_MAX_WORDS || e != -1) begin
      errors++;
      $display("FAIL max_done: got edge %0d err %0d expected %0d", d, e, 4 + 5 * DEF_MAX_WORDS);
    end
    check_writes("max");
  endtask

  task automatic test_mid_reset();
    int d, e;
    do_reset();
    make_image(32'd3, 3);
    run_stream(0, 1'b0, 11, d, e);
    checks++;
    if (wr_adr.size() != 1 || tx_q.size() != 6) begin
      errors++;
      $display("FAIL midrst_pre: got writes %0d left %0d expected 1 and 6", wr_adr.size(), tx_q.size());
    end
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = tx_q[0];
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rx_ready !== 1'b0 || core_rst !== 1'b1 || boot_done !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_adr !== DEF_BASE_ADDR) begin
      errors++;
      $display("FAIL midrst_hold: got rdy%b crst%b done%b we%b adr%h expected 0 1 0 0 %h",
               bus.rx_ready, core_rst, boot_done, bus.mem_we, bus.mem_adr, DEF_BASE_ADDR);
    end
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    make_image(32'd1, 1);
    run_stream(0, 1'b0, 200, d, e);
    checks++;
    if (d != 9) begin
      errors++;
      $display("FAIL midrst_fresh: got done edge %0d expected 9", d);
    end
    check_writes("midrst");
  endtask

  task automatic test_handoff();
    bus.core_adr = 32'h40;
    bus.core_we = 1'b1;
    bus.core_wd = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.mem_adr !== 32'h40 || bus.mem_we !== 1'b1 || bus.mem_wd !== 32'hDEADBEEF || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL handoff_mux: got %h we%b %h crst%b expected 40 we1 deadbeef crst0",
               bus.mem_adr, bus.mem_we, bus.mem_wd, core_rst);
    end
    bus.core_we = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL handoff_we0: got %b expected 0", bus.mem_we);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || boot_done !== 1'b0 || bus.mem_adr !== DEF_BASE_ADDR) begin
      errors++;
      $display("FAIL rearm: got crst%b done%b adr%h expected crst1 done0 %h", core_rst, boot_done, bus.mem_adr, DEF_BASE_ADDR);
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.core_adr = 32'h0;
    bus.core_we = 1'b0;
    bus.core_wd = 32'h0;
    test_reset();
    test_plan_n2();
    test_zero();
    test_err(32'(DEF_MAX_WORDS + 1));
    test_err(32'h8000_0000);
    test_toggle();
    test_random();
    test_max();
    test_mid_reset();
    test_handoff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
